wb_master_core: RTL and testbench

- Wishbone classic single-transfer initiator.
- Accepts one read or write command from a simple valid/ready port and drives it onto a Wishbone B4 classic bus.
- Waits for the slave's ack or err, with a timeout, and returns one response pulse to the requester.
- Acts as the initiating end toward the team's memory/Wishbone slave core and is the bus driver for system-level benches and integration.

---
 rtl/wb_master_pkg.sv | 28 ++
 rtl/wb_master_props.sv | 52 +++++
 rtl/wb_timeout_cnt.sv | 39 +++
 rtl/wb_master_core.sv | 147 ++++++++++++++
 tb/tb_wb_master_core.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_master_pkg.sv
// Shared types for the Wishbone classic single-transfer initiator.
// Holds FSM state encoding, default widths, command bundle and counter helper.
package wb_master_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int SEL_WIDTH  = DATA_W_DEF / 8;
  localparam int CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [SEL_WIDTH-1:0]  sel;
  } cmd_t;

  // Last counter value before a transfer is declared timed out.
  function automatic logic [CNT_WIDTH-1:0] cnt_limit(input int cycles);
    return CNT_WIDTH'(cycles - 1);
  endfunction

endpackage

// File: rtl/wb_master_props.sv
// Protocol checks for wb_master_core, bound into every instance.
// Ports: observes clk, reset, Wishbone outputs and rsp_valid (all inputs).
module wb_master_props #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input logic                    clk,
  input logic                    reset,
  input logic                    wb_cyc_o,
  input logic                    wb_stb_o,
  input logic                    wb_we_o,
  input logic [ADDR_WIDTH-1:0]   wb_adr_o,
  input logic [DATA_WIDTH-1:0]   wb_dat_o,
  input logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input logic                    rsp_valid
);

  a_stb_cyc : assert property (
    @(posedge clk) disable iff (reset)
    wb_stb_o |-> wb_cyc_o
  );

  // stb staying high means no ack/err ended the transfer, so the
  // bus fields must not have moved since the previous cycle.
  a_stable : assert property (
    @(posedge clk) disable iff (reset)
    (wb_stb_o && $past(wb_stb_o)) |->
      ($stable(wb_we_o) && $stable(wb_adr_o) &&
       $stable(wb_dat_o) && $stable(wb_sel_o))
  );

  a_rsp_pulse : assert property (
    @(posedge clk) disable iff (reset)
    rsp_valid |=> !rsp_valid
  );

endmodule

bind wb_master_core wb_master_props #(
  .ADDR_WIDTH(ADDR_WIDTH),
  .DATA_WIDTH(DATA_WIDTH)
) u_props (
  .clk      (clk),
  .reset    (reset),
  .wb_cyc_o (wb_cyc_o),
  .wb_stb_o (wb_stb_o),
  .wb_we_o  (wb_we_o),
  .wb_adr_o (wb_adr_o),
  .wb_dat_o (wb_dat_o),
  .wb_sel_o (wb_sel_o),
  .rsp_valid(rsp_valid)
);

// File: rtl/wb_timeout_cnt.sv
// Bus-phase watchdog: 8-bit clear/enable counter with expiry flag.
// Ports: clk, reset, clr_i, en_i in; expired_o high when count == LIMIT-1.
module wb_timeout_cnt
  import wb_master_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_WIDTH-1:0] LAST = cnt_limit(LIMIT);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/wb_master_core.sv
// Wishbone B4 classic single-transfer initiator with ack/err/timeout.
// Ports: cmd_* request (valid/ready), rsp_* one-cycle result, wb_* bus.
module wb_master_core
  import wb_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_sel,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int SW = DATA_WIDTH / 8;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]         sel;
  } bus_cmd_t;

  state_t   state_q, state_d;
  bus_cmd_t cmd_q, cmd_d;
  logic     cyc_q, cyc_d;
  logic     rvld_q, rvld_d;
  logic     rerr_q, rerr_d;
  logic     rto_q, rto_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;

  logic cnt_clr;
  logic cnt_en;
  logic expired;

  wb_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .expired_o(expired)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cyc_d   = cyc_q;
    rvld_d  = 1'b0;
    rerr_d  = 1'b0;
    rto_d   = 1'b0;
    rdat_d  = '0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (cmd_valid) begin
          cmd_d.we    = cmd_we;
          cmd_d.addr  = cmd_addr;
          cmd_d.wdata = cmd_wdata;
          cmd_d.sel   = cmd_sel;
          cyc_d       = 1'b1;
          state_d     = BUS;
        end
      end
      BUS: begin
        cnt_en = 1'b1;
        // err beats ack, and either beats an expiring watchdog.
        if (wb_err_i || wb_ack_i || expired) begin
          cyc_d   = 1'b0;
          cmd_d   = '0;
          rvld_d  = 1'b1;
          state_d = RESP;
          if (wb_err_i) begin
            rerr_d = 1'b1;
          end else if (wb_ack_i) begin
            rdat_d = cmd_q.we ? '0 : wb_dat_i;
          end else begin
            rerr_d = 1'b1;
            rto_d  = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        cmd_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      cyc_q   <= 1'b0;
      rvld_q  <= 1'b0;
      rerr_q  <= 1'b0;
      rto_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cyc_q   <= cyc_d;
      rvld_q  <= rvld_d;
      rerr_q  <= rerr_d;
      rto_q   <= rto_d;
      rdat_q  <= rdat_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = rvld_q;
  assign rsp_rdata   = rdat_q;
  assign rsp_err     = rerr_q;
  assign rsp_timeout = rto_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = cmd_q.we;
  assign wb_adr_o    = cmd_q.addr;
  assign wb_dat_o    = cmd_q.wdata;
  assign wb_sel_o    = cmd_q.sel;

endmodule

// File: tb/tb_wb_master_core.sv
// Self-checking bench for wb_master_core with a small memory slave.
// Responses are scored against a queue of expected results.
module tb_wb_master_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  always #5 clk = ~clk;

  wb_master_core #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_sel    (cmd_sel),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- slave model ----------------
  logic [31:0] mem [256];
  int          stb_cnt = 0;
  int          ack_dly = 0;
  bit          no_ack = 0;
  bit          ack_err = 0;
  bit          stray_ack = 0;
  bit          use_ovr = 0;
  logic [31:0] dat_ovr = 32'h0;
  logic        s_hit;

  assign s_hit    = wb_stb_o && wb_cyc_o && (stb_cnt == ack_dly) && !no_ack;
  assign wb_ack_i = s_hit || stray_ack;
  assign wb_err_i = s_hit && ack_err;
  assign wb_dat_i = use_ovr ? dat_ovr : mem[wb_adr_o];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | 32'(i);
  end

  always @(posedge clk) begin
    if (wb_stb_o && !wb_ack_i && !wb_err_i) stb_cnt <= stb_cnt + 1;
    else stb_cnt <= 0;
    if (wb_stb_o && wb_ack_i && !wb_err_i && wb_we_o) begin
      for (int b = 0; b < 4; b++)
        if (wb_sel_o[b]) mem[wb_adr_o][b*8 +: 8] <= wb_dat_o[b*8 +: 8];
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    logic        to;
    int          stb_len;
  } exp_t;

  exp_t exp_q[$];
  int   stb_run = 0;
  int   stb_last = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) stb_run = 0;
    else if (wb_stb_o) stb_run++;
    else if (stb_run != 0) begin
      stb_last = stb_run;
      stb_run  = 0;
    end
    if (rsp_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL spurious_rsp: got rsp_valid=1 err=%0b, required no response",
                 rsp_err);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_rdata, rsp_err, rsp_timeout} !== {e.rdata, e.err, e.to}) begin
          fails++;
          $display("FAIL %s_rsp: got rdata=%h err=%0b to=%0b, required rdata=%h err=%0b to=%0b",
                   e.name, rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.to);
        end
        if (e.stb_len > 0) begin
          tests++;
          if (stb_last != e.stb_len) begin
            fails++;
            $display("FAIL %s_stb_len: got %0d cycles, required %0d",
                     e.name, stb_last, e.stb_len);
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic push_exp(input string n, input logic [31:0] d,
                          input logic er, input logic t, input int len);
    exp_t e;
    e.name = n; e.rdata = d; e.err = er; e.to = t; e.stb_len = len;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge just after acceptance.
  task automatic send_cmd(input logic we, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input bit hold, input string n);
    bit ok = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_sel   = s;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (cmd_ready) ok = 1;
      @(negedge clk);
    end
    if (!hold) cmd_valid = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_accept: got no cmd_ready in 64 cycles, required acceptance", n);
    end
  endtask

  task automatic wait_done(input string n);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (exp_q.size() == 0 && cmd_ready) ok = 1;
      else @(negedge clk);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_done: got %0d pending responses, required 0",
               n, exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_sel = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got %b, required 1", cmd_ready);
    end
    tests++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin
      fails++; $display("FAIL reset_cyc_stb_we: got %b, required 000",
                        {wb_cyc_o, wb_stb_o, wb_we_o});
    end
    tests++;
    if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 44'h0) begin
      fails++; $display("FAIL reset_bus: got %h, required 0",
                        {wb_adr_o, wb_dat_o, wb_sel_o});
    end
    tests++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== 35'h0) begin
      fails++; $display("FAIL reset_rsp: got %h, required 0",
                        {rsp_valid, rsp_err, rsp_timeout, rsp_rdata});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    ack_dly = 1; no_ack = 0; ack_err = 0; use_ovr = 0;
    push_exp("write", 32'h0, 1'b0, 1'b0, 2);
    send_cmd(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, "write");
    tests++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b111) begin
      fails++; $display("FAIL write_ctl: got %b, required 111",
                        {wb_cyc_o, wb_stb_o, wb_we_o});
    end
    tests++;
    if (wb_adr_o !== 8'h10 || wb_dat_o !== 32'hDEADBEEF || wb_sel_o !== 4'hF) begin
      fails++; $display("FAIL write_bus: got adr=%h dat=%h sel=%h, required 10 deadbeef f",
                        wb_adr_o, wb_dat_o, wb_sel_o);
    end
    tests++;
    if (cmd_ready !== 1'b0) begin
      fails++; $display("FAIL write_busy_ready: got %b, required 0", cmd_ready);
    end
    wait_done("write");
    tests++;
    if ({wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} !== 45'h0) begin
      fails++; $display("FAIL write_bus_cleared: got adr=%h dat=%h, required 0",
                        wb_adr_o, wb_dat_o);
    end
  endtask

  task automatic test_read();
    ack_dly = 0;
    push_exp("read", 32'hDEADBEEF, 1'b0, 1'b0, 1);
    send_cmd(1'b0, 8'h10, 32'h0, 4'hF, 1'b0, "read");
    tests++;
    if (wb_we_o !== 1'b0 || wb_adr_o !== 8'h10) begin
      fails++; $display("FAIL read_bus: got we=%b adr=%h, required 0 10",
                        wb_we_o, wb_adr_o);
    end
    wait_done("read");
  endtask

  task automatic test_timeout();
    no_ack = 1;
    push_exp("timeout", 32'h0, 1'b1, 1'b1, 16);
    send_cmd(1'b0, 8'h20, 32'h0, 4'hF, 1'b0, "timeout");
    wait_done("timeout");
    no_ack = 0;
  endtask

  task automatic test_ack_on_timeout();
    ack_dly = 15;
    push_exp("ack_last", 32'hDEADBEEF, 1'b0, 1'b0, 16);
    send_cmd(1'b0, 8'h10, 32'h0, 4'hF, 1'b0, "ack_last");
    wait_done("ack_last");
    ack_dly = 0;
  endtask

  task automatic test_ack_err();
    ack_dly = 0; ack_err = 1; use_ovr = 1; dat_ovr = 32'h12345678;
    push_exp("ack_err", 32'h0, 1'b1, 1'b0, 1);
    send_cmd(1'b0, 8'h24, 32'h0, 4'hF, 1'b0, "ack_err");
    wait_done("ack_err");
    ack_err = 0; use_ovr = 0;
  endtask

  task automatic test_reset_mid();
    no_ack = 1;
    send_cmd(1'b1, 8'h30, 32'hCAFEF00D, 4'hF, 1'b0, "rst_mid");
    @(negedge clk);
    tests++;
    if (wb_stb_o !== 1'b1) begin
      fails++; $display("FAIL rst_mid_stb2: got %b, required 1", wb_stb_o);
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({wb_cyc_o, wb_stb_o, rsp_valid} !== 3'b000) begin
      fails++; $display("FAIL rst_mid_drop: got cyc/stb/rsp=%b, required 000",
                        {wb_cyc_o, wb_stb_o, rsp_valid});
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL rst_mid_ready: got %b, required 1", cmd_ready);
    end
    no_ack = 0;
    repeat (4) @(negedge clk);
    tests++;
    if (mem[8'h30] !== 32'hC0DE0030) begin
      fails++; $display("FAIL rst_mid_nowrite: got mem=%h, required c0de0030",
                        mem[8'h30]);
    end
  endtask

  task automatic test_back_to_back();
    stray_ack = 1;
    @(negedge clk);
    stray_ack = 0;
    repeat (3) @(negedge clk);
    ack_dly = 2;
    for (int i = 0; i < 4; i++) begin
      push_exp($sformatf("b2b%0d", i), 32'hC0DE0000 | 32'(i), 1'b0, 1'b0, 3);
      send_cmd(1'b0, 8'(i), 32'h0, 4'hF, 1'b1, $sformatf("b2b%0d", i));
      tests++;
      if (wb_stb_o !== 1'b1 || wb_adr_o !== 8'(i)) begin
        fails++; $display("FAIL b2b%0d_bus: got stb=%b adr=%h, required 1 %h",
                          i, wb_stb_o, wb_adr_o, 8'(i));
      end
    end
    cmd_valid = 1'b0;
    wait_done("b2b");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_on_timeout();
    test_ack_err();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
